// File: rtl/kara_mul_pipe_if.sv
// rtl/kara_mul_pipe_if.sv - operand/product handshake bundle for kara_mul_pipe
interface kara_mul_pipe_if #(
  parameter int WIDTH = 34,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );
endinterface

// File: rtl/kara_mul_pipe.sv
// rtl/kara_mul_pipe.sv - four-stage one-level Karatsuba unsigned multiplier
module kara_mul_pipe #(
  parameter int WIDTH = 34,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  kara_mul_pipe_if.slave   bus,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic             en;
  logic             v1_q, v2_q, v3_q, v4_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;
  logic [2*H-1:0]   p0_2_q, p2_2_q, p0_3_q, p2_3_q;
  logic [2*H+1:0]   p11_q;
  logic [2*H:0]     mid_q;
  logic [PW-1:0]    p4_q;
  logic [CNT_W-1:0] cnt_q;

  logic [H:0]       sum_a, sum_b;
  logic [2*H-1:0]   p0_d, p2_d;
  logic [2*H+1:0]   p11_d, mid_full;
  logic [2*H:0]     mid_d;
  logic [PW-1:0]    p4_d;
  logic             unused_mid_msb;

  // Global stall: only a presented-but-unaccepted product freezes the pipe.
  assign en            = ~(v4_q & ~bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = v4_q;
  assign bus.out_p     = p4_q;
  assign bus.out_tag   = tag4_q;
  assign done_cnt      = cnt_q;

  // Split the S1 operands into halves and form the three partial products.
  always_comb begin
    sum_a = {1'b0, s1_a_q[H-1:0]} + {1'b0, s1_a_q[WIDTH-1:H]};
    sum_b = {1'b0, s1_b_q[H-1:0]} + {1'b0, s1_b_q[WIDTH-1:H]};
    p0_d  = {{H{1'b0}}, s1_a_q[H-1:0]} * {{H{1'b0}}, s1_b_q[H-1:0]};
    p2_d  = {{H{1'b0}}, s1_a_q[WIDTH-1:H]} * {{H{1'b0}}, s1_b_q[WIDTH-1:H]};
    p11_d = {{(H+1){1'b0}}, sum_a} * {{(H+1){1'b0}}, sum_b};
  end

  // Middle term and final recombination; mid is a0*b1 + a1*b0 so its top bit is always clear.
  always_comb begin
    mid_full = p11_q - {2'b00, p0_2_q} - {2'b00, p2_2_q};
    mid_d    = mid_full[2*H:0];
    p4_d     = {{(PW-2*H){1'b0}}, p0_3_q}
             + ({{(PW-2*H-1){1'b0}}, mid_q} << H)
             + ({{(PW-2*H){1'b0}}, p2_3_q} << (2*H));
  end

  assign unused_mid_msb = mid_full[2*H+1];

  // Pipeline stages; bubbles travel with their slot and every stage holds on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      tag4_q <= '0;
      p0_2_q <= '0;
      p2_2_q <= '0;
      p11_q  <= '0;
      mid_q  <= '0;
      p0_3_q <= '0;
      p2_3_q <= '0;
      p4_q   <= '0;
    end else if (en) begin
      v1_q   <= bus.in_valid;
      s1_a_q <= bus.in_a;
      s1_b_q <= bus.in_b;
      tag1_q <= bus.in_tag;
      v2_q   <= v1_q;
      tag2_q <= tag1_q;
      p0_2_q <= p0_d;
      p2_2_q <= p2_d;
      p11_q  <= p11_d;
      v3_q   <= v2_q;
      tag3_q <= tag2_q;
      mid_q  <= mid_d;
      p0_3_q <= p0_2_q;
      p2_3_q <= p2_2_q;
      v4_q   <= v3_q;
      tag4_q <= tag3_q;
      p4_q   <= p4_d;
    end
  end

  // Count consumed products, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (v4_q && bus.out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
